// File: rtl/time_param_timer.sv
// Reprogrammable store of NUM_PARAMS clamped time parameters with registered
// readback, plus a countdown timer loaded from a selected parameter and run on 1 Hz ticks.
module time_param_timer #(
  parameter int NUM_PARAMS = 4,
  parameter int TIME_W     = 4,
  parameter int SEL_W      = 2,
  parameter logic [NUM_PARAMS*TIME_W-1:0] DEFAULTS = 16'h4236,
  parameter int MIN_TIME   = 1,
  parameter int MAX_TIME   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic [SEL_W-1:0]  selector,
  output logic [TIME_W-1:0] t_value_output,
  input  logic              reprogram,
  input  logic [SEL_W-1:0]  selector_reprogram,
  input  logic [TIME_W-1:0] t_value_input,
  input  logic              start,
  output logic              busy,
  output logic [TIME_W-1:0] remaining,
  output logic              expired,
  output logic              sel_error
);
  localparam logic [TIME_W-1:0] MIN_V = TIME_W'(MIN_TIME);
  localparam logic [TIME_W-1:0] MAX_V = TIME_W'(MAX_TIME);
  localparam logic [SEL_W:0]    NUM_V = (SEL_W+1)'(NUM_PARAMS);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q;
  logic [TIME_W-1:0] param_q [NUM_PARAMS];
  logic [TIME_W-1:0] param_d [NUM_PARAMS];
  logic [TIME_W-1:0] t_value_q;
  logic [TIME_W-1:0] remaining_q;
  logic              busy_q;
  logic              expired_q;
  logic              sel_error_q;
  logic              rd_valid_s;
  logic              wr_valid_s;

  // Compared one bit wider so full-range limits never make a comparison trivially constant.
  function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] v);
    logic [TIME_W:0] w;
    w = {1'b0, v};
    if (w < {1'b0, MIN_V}) begin
      return MIN_V;
    end else if (w > {1'b0, MAX_V}) begin
      return MAX_V;
    end else begin
      return v;
    end
  endfunction

  assign rd_valid_s = ({1'b0, selector} < NUM_V);
  assign wr_valid_s = ({1'b0, selector_reprogram} < NUM_V);

  // A write to a nonexistent index saturates every parameter so the fault shows in timing.
  always_comb begin
    param_d = param_q;
    if (reprogram && wr_valid_s) begin
      param_d[selector_reprogram] = clamp_time(t_value_input);
    end else if (reprogram) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        param_d[i] = MAX_V;
      end
    end else begin
      param_d = param_q;
    end
  end

  // Parameter storage, readback and countdown FSM; loads use pre-write parameter values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        param_q[i] <= DEFAULTS[i*TIME_W +: TIME_W];
      end
      state_q     <= IDLE;
      t_value_q   <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      expired_q   <= 1'b0;
      sel_error_q <= 1'b0;
    end else begin
      param_q     <= param_d;
      t_value_q   <= rd_valid_s ? param_q[selector] : '0;
      sel_error_q <= start && !rd_valid_s;
      expired_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && rd_valid_s) begin
            state_q     <= RUN;
            remaining_q <= param_q[selector];
            busy_q      <= 1'b1;
          end
        end
        RUN: begin
          if (start && rd_valid_s) begin
            remaining_q <= param_q[selector];
          end else if (tick_1hz) begin
            if (remaining_q == TIME_W'(1)) begin
              state_q     <= IDLE;
              remaining_q <= '0;
              busy_q      <= 1'b0;
              expired_q   <= 1'b1;
            end else begin
              remaining_q <= remaining_q - TIME_W'(1);
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          remaining_q <= '0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign t_value_output = t_value_q;
  assign remaining      = remaining_q;
  assign busy           = busy_q;
  assign expired        = expired_q;
  assign sel_error      = sel_error_q;
endmodule

// File: tb/tb_time_param_timer.sv
// Bench for time_param_timer: three configurations driven in parallel and compared
// against a per-cycle arithmetic model of the parameter store and countdown.
module tb_time_param_timer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic [1:0] sel = 2'd0;
  logic reprogram = 1'b0;
  logic [1:0] srp = 2'd0;
  logic [3:0] tin = 4'd0;
  logic start = 1'b0;

  logic [3:0] tout_w [3];
  logic [3:0] rem_w  [3];
  logic       busy_w [3];
  logic       exp_w  [3];
  logic       serr_w [3];

  int n_cmp = 0;
  int n_bad = 0;

  // model state: instance 0 default, 1 clamps to [2,8], 2 has only three params
  int cnum [3] = '{4, 4, 3};
  int cmin [3] = '{1, 2, 1};
  int cmax [3] = '{15, 8, 15};
  int dflt [4] = '{6, 3, 2, 4};
  int mp   [3][4];
  int mrem [3];
  int mtout[3];
  bit mexp [3];
  bit mserr[3];

  always #5 clk = ~clk;

  time_param_timer u_a (
    .clk(clk), .reset(reset), .tick_1hz(tick), .selector(sel),
    .t_value_output(tout_w[0]), .reprogram(reprogram), .selector_reprogram(srp),
    .t_value_input(tin), .start(start), .busy(busy_w[0]), .remaining(rem_w[0]),
    .expired(exp_w[0]), .sel_error(serr_w[0]));

  time_param_timer #(.MIN_TIME(2), .MAX_TIME(8)) u_b (
    .clk(clk), .reset(reset), .tick_1hz(tick), .selector(sel),
    .t_value_output(tout_w[1]), .reprogram(reprogram), .selector_reprogram(srp),
    .t_value_input(tin), .start(start), .busy(busy_w[1]), .remaining(rem_w[1]),
    .expired(exp_w[1]), .sel_error(serr_w[1]));

  time_param_timer #(.NUM_PARAMS(3), .DEFAULTS(12'h236)) u_c (
    .clk(clk), .reset(reset), .tick_1hz(tick), .selector(sel),
    .t_value_output(tout_w[2]), .reprogram(reprogram), .selector_reprogram(srp),
    .t_value_input(tin), .start(start), .busy(busy_w[2]), .remaining(rem_w[2]),
    .expired(exp_w[2]), .sel_error(serr_w[2]));

  function automatic logic [10:0] obs(int k);
    return {busy_w[k], rem_w[k], exp_w[k], serr_w[k], tout_w[k]};
  endfunction

  function automatic logic [10:0] expv(int k);
    return {(mrem[k] != 0), 4'(mrem[k]), mexp[k], mserr[k], 4'(mtout[k])};
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) mp[k][j] = dflt[j];
      mrem[k] = 0; mtout[k] = 0; mexp[k] = 1'b0; mserr[k] = 1'b0;
    end
  endfunction

  // Advance one clock: compute model next state from current inputs, commit at the edge.
  task automatic step();
    int nrem[3]; int ntout[3]; bit nexp[3]; bit nserr[3]; int np[3][4];
    bit sv; int v;
    for (int k = 0; k < 3; k++) begin
      sv = (int'(sel) < cnum[k]);
      ntout[k] = sv ? mp[k][sel] : 0;
      nserr[k] = start && !sv;
      nexp[k] = 1'b0;
      nrem[k] = mrem[k];
      if (start && sv) nrem[k] = mp[k][sel];
      else if (mrem[k] > 0 && tick) begin
        nrem[k] = mrem[k] - 1;
        nexp[k] = (nrem[k] == 0);
      end
      for (int j = 0; j < 4; j++) np[k][j] = mp[k][j];
      if (reprogram) begin
        if (int'(srp) < cnum[k]) begin
          v = int'(tin);
          np[k][srp] = (v < cmin[k]) ? cmin[k] : (v > cmax[k]) ? cmax[k] : v;
        end else begin
          for (int j = 0; j < cnum[k]; j++) np[k][j] = cmax[k];
        end
      end
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      mrem[k] = nrem[k]; mtout[k] = ntout[k]; mexp[k] = nexp[k]; mserr[k] = nserr[k];
      for (int j = 0; j < 4; j++) mp[k][j] = np[k][j];
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; tick = 1'b0; reprogram = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs(k) !== 11'd0) begin
        n_bad++;
        $display("FAIL reset inst%0d: got %h want %h", k, obs(k), 11'd0);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_readback();
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      step();
      n_cmp++;
      if (tout_w[0] !== 4'(dflt[s])) begin
        n_bad++;
        $display("FAIL readback_default sel%0d: got %0d want %0d", s, tout_w[0], dflt[s]);
      end
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL readback inst%0d: got %h want %h", k, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_reprogram();
    int want_b [4] = '{0, 2, 8, 5};
    apply_reset();
    reprogram = 1'b1;
    srp = 2'd1; tin = 4'd0; step();
    srp = 2'd2; tin = 4'd9; step();
    srp = 2'd3; tin = 4'd5; step();
    reprogram = 1'b0;
    for (int s = 1; s < 4; s++) begin
      sel = 2'(s);
      step();
      n_cmp++;
      if (tout_w[1] !== 4'(want_b[s])) begin
        n_bad++;
        $display("FAIL clamp sel%0d: got %0d want %0d", s, tout_w[1], want_b[s]);
      end
      n_cmp++;
      if (s < 3 && tout_w[2] !== 4'd15) begin
        n_bad++;
        $display("FAIL bad_index_saturate sel%0d: got %0d want 15", s, tout_w[2]);
      end
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL reprogram inst%0d: got %h want %h", k, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_countdown();
    int pulses = 0;
    apply_reset();
    sel = 2'd2; start = 1'b1; step(); start = 1'b0;
    n_cmp++;
    if ({busy_w[0], rem_w[0]} !== {1'b1, 4'd2}) begin
      n_bad++;
      $display("FAIL countdown_load: got %b/%0d want 1/2", busy_w[0], rem_w[0]);
    end
    for (int i = 0; i < 25; i++) begin
      tick = (i == 4 || i == 14);
      step();
      tick = 1'b0;
      if (exp_w[0] === 1'b1) pulses++;
      if (i == 14) begin
        n_cmp++;
        if (exp_w[0] !== 1'b1) begin
          n_bad++;
          $display("FAIL expired_timing: got %b want 1", exp_w[0]);
        end
      end
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL countdown inst%0d cyc%0d: got %h want %h", k, i, obs(k), expv(k));
        end
      end
    end
    n_cmp++;
    if (pulses != 1 || busy_w[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL expired_once: got %0d pulses busy %b want 1 pulse busy 0", pulses, busy_w[0]);
    end
  endtask

  task automatic test_restart();
    apply_reset();
    sel = 2'd0; start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin tick = 1'b1; step(); tick = 1'b0; step(); end
    n_cmp++;
    if (rem_w[0] !== 4'd3) begin
      n_bad++;
      $display("FAIL restart_pre: got %0d want 3", rem_w[0]);
    end
    sel = 2'd1; start = 1'b1; tick = 1'b1; step(); start = 1'b0; tick = 1'b0;
    n_cmp++;
    if (rem_w[0] !== 4'd3) begin
      n_bad++;
      $display("FAIL restart_tick_ignored: got %0d want 3", rem_w[0]);
    end
    for (int i = 0; i < 2; i++) begin tick = 1'b1; step(); tick = 1'b0; step(); end
    n_cmp++;
    if (rem_w[0] !== 4'd1) begin
      n_bad++;
      $display("FAIL restart_last: got %0d want 1", rem_w[0]);
    end
    start = 1'b1; tick = 1'b1; step(); start = 1'b0; tick = 1'b0;
    n_cmp++;
    if ({busy_w[0], rem_w[0], exp_w[0]} !== {1'b1, 4'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL start_beats_expire: got %b/%0d/%b want 1/3/0", busy_w[0], rem_w[0], exp_w[0]);
    end
    step();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs(k) !== expv(k)) begin
        n_bad++;
        $display("FAIL restart inst%0d: got %h want %h", k, obs(k), expv(k));
      end
    end
  endtask

  task automatic test_reprog_run();
    apply_reset();
    sel = 2'd3; start = 1'b1; step(); start = 1'b0;
    reprogram = 1'b1; srp = 2'd3; tin = 4'd15; step(); reprogram = 1'b0;
    for (int n = 3; n >= 0; n--) begin
      tick = 1'b1; step(); tick = 1'b0;
      n_cmp++;
      if (rem_w[0] !== 4'(n)) begin
        n_bad++;
        $display("FAIL reprog_run_count: got %0d want %0d", rem_w[0], n);
      end
    end
    start = 1'b1; step(); start = 1'b0;
    n_cmp++;
    if ({rem_w[0], rem_w[1]} !== {4'd15, 4'd8}) begin
      n_bad++;
      $display("FAIL reprog_reload: got %0d,%0d want 15,8", rem_w[0], rem_w[1]);
    end
    n_cmp++;
    if ({serr_w[2], busy_w[2]} !== 2'b10) begin
      n_bad++;
      $display("FAIL sel_error_pulse: got %b%b want 10", serr_w[2], busy_w[2]);
    end
    step();
    n_cmp++;
    if ({serr_w[2], busy_w[2]} !== 2'b00) begin
      n_bad++;
      $display("FAIL sel_error_single: got %b%b want 00", serr_w[2], busy_w[2]);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs(k) !== expv(k)) begin
        n_bad++;
        $display("FAIL reprog_run inst%0d: got %h want %h", k, obs(k), expv(k));
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    sel = 2'd0; start = 1'b1; step(); start = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    n_cmp++;
    if (rem_w[0] !== 4'd5) begin
      n_bad++;
      $display("FAIL async_pre: got %0d want 5", rem_w[0]);
    end
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({busy_w[k], rem_w[k], exp_w[k]} !== 6'd0) begin
        n_bad++;
        $display("FAIL async_reset inst%0d: got %b/%0d/%b want 0/0/0", k, busy_w[k], rem_w[k], exp_w[k]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      step();
      n_cmp++;
      if (tout_w[0] !== 4'(dflt[s])) begin
        n_bad++;
        $display("FAIL async_defaults sel%0d: got %0d want %0d", s, tout_w[0], dflt[s]);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      tick = ($urandom_range(0, 2) == 0);
      start = ($urandom_range(0, 7) == 0);
      reprogram = ($urandom_range(0, 5) == 0);
      sel = 2'($urandom_range(0, 3));
      srp = 2'($urandom_range(0, 3));
      tin = 4'($urandom_range(0, 15));
      step();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL random inst%0d cyc%0d: got %h want %h", k, i, obs(k), expv(k));
        end
      end
    end
    tick = 1'b0; start = 1'b0; reprogram = 1'b0;
  endtask

  initial begin
    test_reset();
    test_readback();
    test_reprogram();
    test_countdown();
    test_restart();
    test_reprog_run();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
